handshake_responder: RTL and testbench
======================================

// Module: handshake_responder
//
// PURPOSE
//   Responder end of a four-phase req/ack handshake. Pairs with the team's
//   Moore/Mealy initiator FSMs.
//   Samples req, captures a data word, and holds busy for a fixed service
//   delay. It then raises ack until the initiator drops req, and counts
//   completed transactions.
//   Protocol violations are flagged on a one-cycle err pulse.
//
// PARAMETERS
//   DATA_W   8    width of data_in/data_out
//   DELAY    4    service cycles spent in BUSY, legal range 1..255
//   CNT_W    8    width of done_count; wraps modulo 2**CNT_W
//   TIMEOUT  16   cycles ack may stay high before abort (TIMEOUT_EN only), >=1
//
// PORTS
//   clock       in   1        rising-edge clock
//   n_reset     in   1        asynchronous active-low reset
//   req         in   1        initiator request, synchronous to clock
//   data_in     in   DATA_W   payload; valid on the cycle req is first seen high
//   ack         out  1        acknowledge (Moore, decoded from state)
//   busy        out  1        high while servicing (Moore)
//   err         out  1        one-cycle protocol-error pulse (registered)
//   data_out    out  DATA_W   captured payload (registered)
//   done_count  out  CNT_W    completed-transaction counter (registered)
//
// BEHAVIOUR
//   Reset (async, n_reset=0):
//     - state=IDLE; ack=0, busy=0, err=0; data_out=0, done_count=0;
//       internal counters=0.
//     - Applies immediately, including mid-transaction; no ack or count results.
//   IDLE:
//     - req=1 at edge k: data_out<=data_in, delay counter<=DELAY-1, go to BUSY.
//     - Otherwise stay in IDLE.
//   BUSY (busy=1):
//     - Counter decrements each cycle. At count==0 go to ACK.
//     - busy is therefore high for exactly DELAY cycles; ack rises after edge k+DELAY.
//     - req=0 while in BUSY: err=1 for the next cycle, go to IDLE.
//       No ack; done_count unchanged. This check has priority over count==0.
//   ACK (ack=1):
//     - data_out stable.
//     - req=0: go to IDLE; done_count<=done_count+1 (wraps to 0); ack falls
//       on the same edge.
//     - A new req is accepted no earlier than the cycle after returning to IDLE.
//   data_in:
//     - Ignored outside the IDLE capture edge.
//     - data_out holds its value until the next capture.
//   Illegal or unreachable state encoding: go to IDLE, all outputs default.
//   err defaults to 0 every cycle unless an error event occurred on the prior edge.
//
// CONFIGURATION
//   TIMEOUT_EN defined:
//     - Adds an ack-hold counter, cleared on ACK entry.
//     - If req is still 1 after TIMEOUT cycles in ACK: err pulse, ack<=0, go to FLUSH.
//     - FLUSH (ack=0, busy=0) waits for req=0, then goes to IDLE. done_count unchanged.
//     - A req that stays high therefore cannot retrigger a transaction.
//   TIMEOUT_EN undefined:
//     - No FLUSH state and no ack-hold counter.
//     - ACK holds indefinitely until req=0.
//
// TESTING
//   1. DELAY=4: req=1 with data_in=8'hA5 at edge 0.
//      -> busy high for edges 1-4, ack=1 from edge 4, data_out=8'hA5.
//      -> Drop req: ack=0 next edge, done_count=1.
//   2. req dropped after 2 BUSY cycles.
//      -> err=1 for exactly one cycle, back in IDLE.
//      -> ack never asserts; done_count unchanged.
//   3. CNT_W=2: four complete transactions.
//      -> done_count sequence 1,2,3,0.
//   4. n_reset pulsed low during BUSY and again during ACK.
//      -> All outputs 0 immediately.
//      -> A fresh req completes normally afterwards.
//   5. Back-to-back: req low one cycle after ack, then high again with data_in=8'h3C.
//      -> Second capture and ack correct; data_out=8'h3C.
//   6. TIMEOUT_EN, TIMEOUT=16: req held high.
//      -> After 16 ACK cycles: err pulse, ack=0, stay in FLUSH while req=1.
//      -> IDLE after req=0; done_count unchanged.
//      -> Without the macro, ack stays high for 100+ cycles.

Source files
------------

// File: rtl/handshake_responder.sv
// rtl/handshake_responder.sv - four-phase req/ack responder with service delay and done counter.
// Optional TIMEOUT_EN adds an ack-hold timeout that aborts into a FLUSH state.
module handshake_responder #(
  parameter int DATA_W  = 8,
  parameter int DELAY   = 4,
  parameter int CNT_W   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              req,
  input  logic [DATA_W-1:0] data_in,
  output logic              ack,
  output logic              busy,
  output logic              err,
  output logic [DATA_W-1:0] data_out,
  output logic [CNT_W-1:0]  done_count
);

  localparam int DLY_W = 8;
  localparam logic [DLY_W-1:0] DLY_LOAD = DLY_W'(DELAY - 1);

  if (DELAY < 1 || DELAY > 255) begin : g_bad_delay
    $error("handshake_responder: DELAY must be 1..255");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("handshake_responder: TIMEOUT must be >= 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY  = 2'd1,
    ACK   = 2'd2
`ifdef TIMEOUT_EN
    ,FLUSH = 2'd3
`endif
  } state_t;

  state_t              state_q, state_d;
  logic [DLY_W-1:0]    dly_q, dly_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                err_q, err_d;

`ifdef TIMEOUT_EN
  localparam int HOLD_W = $clog2(TIMEOUT + 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(TIMEOUT - 1);
  logic [HOLD_W-1:0]   hold_q, hold_d;

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) hold_q <= '0;
    else          hold_q <= hold_d;
  end
`endif

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= IDLE;
      dly_q   <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dly_q   <= dly_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dly_d   = dly_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    err_d   = 1'b0;
`ifdef TIMEOUT_EN
    hold_d  = hold_q;
`endif
    case (state_q)
      IDLE: begin
        if (req) begin
          data_d  = data_in;
          dly_d   = DLY_LOAD;
          state_d = BUSY;
        end
      end
      BUSY: begin
        // An early req drop wins over service completion on the same edge.
        if (!req) begin
          err_d   = 1'b1;
          dly_d   = '0;
          state_d = IDLE;
        end else if (dly_q == '0) begin
          state_d = ACK;
`ifdef TIMEOUT_EN
          hold_d  = '0;
`endif
        end else begin
          dly_d = dly_q - DLY_W'(1);
        end
      end
      ACK: begin
        if (!req) begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = IDLE;
        end
`ifdef TIMEOUT_EN
        else if (hold_q == HOLD_LAST) begin
          err_d   = 1'b1;
          state_d = FLUSH;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
`endif
      end
`ifdef TIMEOUT_EN
      FLUSH: begin
        if (!req) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  assign ack        = (state_q == ACK);
  assign busy       = (state_q == BUSY);
  assign err        = err_q;
  assign data_out   = data_q;
  assign done_count = cnt_q;

endmodule

// File: tb/tb_handshake_responder.sv
// tb/tb_handshake_responder.sv - table-driven scoreboard bench for handshake_responder.
module tb_handshake_responder;

  localparam int DELAY = 4;
  localparam int TOUT  = 16;

  logic       clock = 1'b0;
  logic       n_reset;
  logic       req;
  logic [7:0] data_in;
  logic       ack, busy, err;
  logic [7:0] data_out;
  logic [1:0] done_count;

  handshake_responder #(.DATA_W(8), .DELAY(DELAY), .CNT_W(2), .TIMEOUT(TOUT)) dut (
    .clock(clock), .n_reset(n_reset), .req(req), .data_in(data_in),
    .ack(ack), .busy(busy), .err(err), .data_out(data_out), .done_count(done_count)
  );

  always #5 clock = ~clock;

  typedef struct {logic [7:0] data; int abort_after; int ack_hold;} vec_t;
  typedef struct {logic [7:0] data; logic err; logic [1:0] count; int busy_len;} exp_t;

  vec_t       vecs[8];
  exp_t       sb[$];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] model_cnt = 2'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic do_txn(input logic [7:0] d, input int abort_after, input int ack_hold);
    exp_t e;
    int   nb;
    bit   hold_ok;
    e.data     = d;
    e.err      = (abort_after != 0);
    e.count    = e.err ? model_cnt : model_cnt + 2'd1;
    e.busy_len = e.err ? abort_after : DELAY;
    model_cnt  = e.count;
    sb.push_back(e);

    req = 1'b1;
    data_in = d;
    tick;
    nb = 0;
    while (busy && nb < 300) begin
      nb++;
      data_in = 8'($urandom);
      if (abort_after != 0 && nb == abort_after) req = 1'b0;
      tick;
    end

    if (sb.size() == 0) begin
      check("sb_empty", 1, 0);
    end else begin
      e = sb.pop_front();
      check("busy_len", nb, e.busy_len);
      check("err", err, e.err);
      check("ack", ack, !e.err);
      check("data_out", data_out, e.data);
      if (!e.err) begin
        hold_ok = 1'b1;
        for (int i = 0; i < ack_hold; i++) begin
          tick;
          if (!ack || data_out !== e.data) hold_ok = 1'b0;
        end
        check("ack_hold", hold_ok, 1);
        req = 1'b0;
        tick;
        check("ack_fall", ack, 0);
      end else begin
        tick;
        check("err_pulse_end", err, 0);
        check("no_ack_after_abort", ack, 0);
      end
      check("done_count", done_count, e.count);
    end
  endtask

  task automatic reset_mid(input bit in_ack);
    req = 1'b1;
    data_in = 8'h11;
    tick;
    if (in_ack) begin
      repeat (DELAY) tick;
      check("pre_reset_ack", ack, 1);
    end else begin
      tick;
      check("pre_reset_busy", busy, 1);
    end
    #2 n_reset = 1'b0;
    #1;
    check("rst_outputs", {ack, busy, err, data_out, done_count}, 0);
    req = 1'b0;
    model_cnt = 2'd0;
    tick;
    n_reset = 1'b1;
    tick;
    check("post_rst_idle", {ack, busy, done_count}, 0);
  endtask

  initial begin
    int  n;
    bit  ok;
    vecs[0] = '{8'hA5, 0, 0};
    vecs[1] = '{8'h5A, 2, 0};
    vecs[2] = '{8'h3C, 0, 3};
    vecs[3] = '{8'hFF, DELAY, 0};
    vecs[4] = '{8'h00, 1, 0};
    vecs[5] = '{8'hC3, 0, 1};
    vecs[6] = '{8'h81, 0, 0};
    vecs[7] = '{8'h7E, 0, 0};

    n_reset = 1'b0;
    req = 1'b0;
    data_in = 8'h00;
    #12;
    check("reset_state", {ack, busy, err, data_out, done_count}, 0);
    tick;
    n_reset = 1'b1;
    tick;

    foreach (vecs[i]) do_txn(vecs[i].data, vecs[i].abort_after, vecs[i].ack_hold);

    reset_mid(1'b0);
    reset_mid(1'b1);
    do_txn(8'h96, 0, 0);

    req = 1'b1;
    data_in = 8'h4B;
    tick;
    n = 0;
    while (busy && n < 300) begin n++; tick; end
    check("to_ack_rise", ack, 1);
`ifdef TIMEOUT_EN
    n = 0;
    while (ack && n < 300) begin n++; tick; end
    check("to_ack_len", n, TOUT);
    check("to_err", err, 1);
    ok = 1'b1;
    repeat (10) begin
      tick;
      if (ack || busy || err) ok = 1'b0;
    end
    check("to_flush_hold", ok, 1);
    req = 1'b0;
    tick;
    tick;
    check("to_done_count", done_count, model_cnt);
    check("to_idle", {ack, busy, err}, 0);
`else
    ok = 1'b1;
    repeat (120) begin
      tick;
      if (!ack || err) ok = 1'b0;
    end
    check("ack_indefinite", ok, 1);
    req = 1'b0;
    tick;
    model_cnt = model_cnt + 2'd1;
    check("long_ack_fall", ack, 0);
    check("long_done_count", done_count, model_cnt);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
